// File: rtl/ahb_uart_fifo_if.sv
`default_nettype none
// ============================================================================
// Module  : ahb_uart_fifo_if
// Brief   : AHB-Lite slave-side bus bundle for the FIFO UART.
// Revision: 1.0
// ============================================================================
interface ahb_uart_fifo_if;
    logic        HSEL;
    logic [15:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
        input  HREADYOUT, HRDATA, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
        output HREADYOUT, HRDATA, HRESP
    );
endinterface
`default_nettype wire

// File: rtl/ahb_uart_fifo.sv
`default_nettype none
// ============================================================================
// Module  : ahb_uart_fifo
// Brief   : AHB-Lite UART with TX/RX FIFOs, runtime baud, parity, stop, IRQ.
// Revision: 1.0
// ============================================================================
module ahb_uart_fifo #(
    parameter int FIFO_DEPTH  = 16,
    parameter int DEFAULT_DIV = 867
) (
    input  wire logic       HCLK,
    input  wire logic       HRESET,
    ahb_uart_fifo_if.slave  ahb,
    output logic            INT_REQ,
    output logic            TX_OUT,
    input  wire logic       RX_IN
);
    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam int c_cw = c_aw + 1;
    localparam logic [c_cw-1:0] c_full    = c_cw'(FIFO_DEPTH);
    localparam logic [c_cw-1:0] c_cnt_one = c_cw'(1);
    localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);
    localparam logic [1:0] c_a_data = 2'd0, c_a_status = 2'd1, c_a_ctrl = 2'd2, c_a_baud = 2'd3;

    typedef enum logic [2:0] {
        TX_IDLE = 3'd0, TX_START = 3'd1, TX_DATA = 3'd2, TX_PARITY = 3'd3, TX_STOP = 3'd4
    } tx_state_t;
    typedef enum logic [2:0] {
        RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2, RX_PARITY = 3'd3, RX_STOP = 3'd4
    } rx_state_t;

    // ---------------- bus pipeline ----------------
    logic       r_dp_valid, r_dp_write;
    logic [1:0] r_dp_addr;
    logic       w_wr, w_rd, w_wr_data, w_wr_status, w_wr_ctrl, w_wr_baud, w_rd_data;
    logic       w_unused;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_addr  <= 2'd0;
        end else if (ahb.HREADY) begin
            r_dp_valid <= ahb.HSEL & ahb.HTRANS[1];
            r_dp_write <= ahb.HWRITE;
            r_dp_addr  <= ahb.HADDR[3:2];
        end
    end

    assign w_wr        = r_dp_valid & ahb.HREADY & r_dp_write;
    assign w_rd        = r_dp_valid & ahb.HREADY & ~r_dp_write;
    assign w_wr_data   = w_wr & (r_dp_addr == c_a_data);
    assign w_wr_status = w_wr & (r_dp_addr == c_a_status);
    assign w_wr_ctrl   = w_wr & (r_dp_addr == c_a_ctrl);
    assign w_wr_baud   = w_wr & (r_dp_addr == c_a_baud);
    assign w_rd_data   = w_rd & (r_dp_addr == c_a_data);
    assign w_unused    = ^{ahb.HADDR[15:4], ahb.HADDR[1:0], ahb.HTRANS[0], ahb.HSIZE, ahb.HWDATA[31:16]};

    assign ahb.HREADYOUT = 1'b1;
    assign ahb.HRESP     = 1'b0;

    // ---------------- control registers ----------------
    logic        r_tx_en, r_rx_en, r_two_stop, r_rx_ie, r_tx_ie;
    logic [1:0]  r_par;
    logic [7:0]  r_thresh;
    logic [15:0] r_div;
    logic        r_ovr, r_perr, r_ferr;
    logic [15:0] w_div_eff;
    logic [16:0] w_div_p1;
    logic        w_par_en, w_par_odd;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_tx_en    <= 1'b1;
            r_rx_en    <= 1'b1;
            r_par      <= 2'b00;
            r_two_stop <= 1'b0;
            r_rx_ie    <= 1'b0;
            r_tx_ie    <= 1'b0;
            r_thresh   <= 8'd1;
            r_div      <= 16'(DEFAULT_DIV);
        end else begin
            if (w_wr_ctrl) begin
                r_tx_en    <= ahb.HWDATA[0];
                r_rx_en    <= ahb.HWDATA[1];
                r_par      <= ahb.HWDATA[3:2];
                r_two_stop <= ahb.HWDATA[4];
                r_rx_ie    <= ahb.HWDATA[5];
                r_tx_ie    <= ahb.HWDATA[6];
                r_thresh   <= ahb.HWDATA[15:8];
            end
            if (w_wr_baud)
                r_div <= ahb.HWDATA[15:0];
        end
    end

    assign w_div_eff = (r_div < 16'd3) ? 16'd3 : r_div;
    assign w_div_p1  = {1'b0, w_div_eff} + 17'd1;
    assign w_par_en  = (r_par == 2'b01) | (r_par == 2'b10);
    assign w_par_odd = (r_par == 2'b10);

    // ---------------- TX FIFO ----------------
    logic [7:0]      r_tx_mem [FIFO_DEPTH];
    logic [c_aw-1:0] r_tx_wp, r_tx_rp;
    logic [c_cw-1:0] r_tx_cnt;
    logic            w_tx_empty, w_tx_full, w_tx_push, w_tx_pop;
    logic [7:0]      w_tx_head;

    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_tx_full  = (r_tx_cnt == c_full);
    assign w_tx_push  = w_wr_data & (~w_tx_full | w_tx_pop);
    assign w_tx_head  = r_tx_mem[r_tx_rp];

    always_ff @(posedge HCLK) begin
        if (w_tx_push)
            r_tx_mem[r_tx_wp] <= ahb.HWDATA[7:0];
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + c_ptr_one;
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + c_ptr_one;
            if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + c_cnt_one;
            else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - c_cnt_one;
        end
    end

    // ---------------- TX FSM ----------------
    tx_state_t   r_tx_state, w_tx_next;
    logic [15:0] r_tx_tmr, r_tx_div;
    logic [2:0]  r_tx_bit;
    logic [7:0]  r_tx_shift;
    logic        r_tx_pbit, r_tx_pen, r_tx_two, r_tx_line;
    logic        w_tx_tick, w_tx_line_nxt;

    assign w_tx_tick = (r_tx_tmr == r_tx_div);

    always_ff @(posedge HCLK) begin
        if (HRESET) r_tx_state <= TX_IDLE;
        else        r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next     = r_tx_state;
        w_tx_pop      = 1'b0;
        w_tx_line_nxt = 1'b1;
        case (r_tx_state)
            TX_IDLE:   if (r_tx_en && !w_tx_empty) begin
                           w_tx_next = TX_START;
                           w_tx_pop  = 1'b1;
                       end
            TX_START:  if (w_tx_tick) w_tx_next = TX_DATA;
            TX_DATA:   if (w_tx_tick && r_tx_bit == 3'd7)
                           w_tx_next = r_tx_pen ? TX_PARITY : TX_STOP;
            TX_PARITY: if (w_tx_tick) w_tx_next = TX_STOP;
            TX_STOP:   if (w_tx_tick && (!r_tx_two || r_tx_bit == 3'd1)) w_tx_next = TX_IDLE;
            default:   w_tx_next = TX_IDLE;
        endcase
        // Line is registered, so look ahead to the bit that the next state transmits.
        case (w_tx_next)
            TX_START:  w_tx_line_nxt = 1'b0;
            TX_DATA:   w_tx_line_nxt = (r_tx_state == TX_DATA && w_tx_tick) ? r_tx_shift[1] : r_tx_shift[0];
            TX_PARITY: w_tx_line_nxt = r_tx_pbit;
            default:   w_tx_line_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_tx_tmr   <= '0;
            r_tx_div   <= 16'd3;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_pbit  <= 1'b0;
            r_tx_pen   <= 1'b0;
            r_tx_two   <= 1'b0;
            r_tx_line  <= 1'b1;
        end else begin
            r_tx_line <= w_tx_line_nxt;
            if (w_tx_pop) begin
                r_tx_tmr   <= '0;
                r_tx_bit   <= '0;
                r_tx_shift <= w_tx_head;
                r_tx_div   <= w_div_eff;
                r_tx_pen   <= w_par_en;
                r_tx_two   <= r_two_stop;
                r_tx_pbit  <= (^w_tx_head) ^ w_par_odd;
            end else if (r_tx_state != TX_IDLE) begin
                if (w_tx_tick) begin
                    r_tx_tmr <= '0;
                    if (r_tx_state == TX_DATA || r_tx_state == TX_STOP)
                        r_tx_bit <= r_tx_bit + 3'd1;
                    if (r_tx_state == TX_DATA)
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                end else begin
                    r_tx_tmr <= r_tx_tmr + 16'd1;
                end
            end
        end
    end

    assign TX_OUT = r_tx_line;

    // ---------------- RX synchroniser + FSM ----------------
    logic        r_rx_s1, r_rx_s2, r_rx_prev;
    rx_state_t   r_rx_state, w_rx_next;
    logic [15:0] r_rx_tmr, r_rx_div, r_rx_half;
    logic [2:0]  r_rx_bit;
    logic [7:0]  r_rx_shift;
    logic        r_rx_pen, r_rx_odd, r_rx_perr;
    logic        w_rx_fall, w_rx_mid, w_rx_push_req;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= RX_IN;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    assign w_rx_fall = r_rx_prev & ~r_rx_s2;
    assign w_rx_mid  = (r_rx_state == RX_START) ? (r_rx_tmr == r_rx_half) : (r_rx_tmr == r_rx_div);

    always_ff @(posedge HCLK) begin
        if (HRESET) r_rx_state <= RX_IDLE;
        else        r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next     = r_rx_state;
        w_rx_push_req = 1'b0;
        case (r_rx_state)
            RX_IDLE:   if (r_rx_en && w_rx_fall) w_rx_next = RX_START;
            RX_START:  if (w_rx_mid) w_rx_next = r_rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:   if (w_rx_mid && r_rx_bit == 3'd7)
                           w_rx_next = r_rx_pen ? RX_PARITY : RX_STOP;
            RX_PARITY: if (w_rx_mid) w_rx_next = RX_STOP;
            RX_STOP:   if (w_rx_mid) begin
                           w_rx_next     = RX_IDLE;
                           w_rx_push_req = 1'b1;
                       end
            default:   w_rx_next = RX_IDLE;
        endcase
    end

    // The edge-detect cycle counts as the first START cycle, hence the timer preload of 1.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_rx_tmr   <= '0;
            r_rx_div   <= 16'd3;
            r_rx_half  <= 16'd2;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_pen   <= 1'b0;
            r_rx_odd   <= 1'b0;
            r_rx_perr  <= 1'b0;
        end else if (r_rx_state == RX_IDLE) begin
            if (r_rx_en && w_rx_fall) begin
                r_rx_tmr  <= 16'd1;
                r_rx_bit  <= '0;
                r_rx_div  <= w_div_eff;
                r_rx_half <= w_div_p1[16:1];
                r_rx_pen  <= w_par_en;
                r_rx_odd  <= w_par_odd;
                r_rx_perr <= 1'b0;
            end
        end else if (w_rx_mid) begin
            r_rx_tmr <= '0;
            if (r_rx_state == RX_DATA) begin
                r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                r_rx_bit   <= r_rx_bit + 3'd1;
            end
            if (r_rx_state == RX_PARITY)
                r_rx_perr <= r_rx_s2 ^ (^r_rx_shift) ^ r_rx_odd;
        end else begin
            r_rx_tmr <= r_rx_tmr + 16'd1;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]      r_rx_mem [FIFO_DEPTH];
    logic [c_aw-1:0] r_rx_wp, r_rx_rp;
    logic [c_cw-1:0] r_rx_cnt;
    logic            w_rx_empty, w_rx_full, w_rx_push, w_rx_pop;

    assign w_rx_empty = (r_rx_cnt == '0);
    assign w_rx_full  = (r_rx_cnt == c_full);
    assign w_rx_pop   = w_rd_data & ~w_rx_empty;
    assign w_rx_push  = w_rx_push_req & (~w_rx_full | w_rx_pop);

    always_ff @(posedge HCLK) begin
        if (w_rx_push)
            r_rx_mem[r_rx_wp] <= r_rx_shift;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_rx_push) r_rx_wp <= r_rx_wp + c_ptr_one;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + c_ptr_one;
            if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + c_cnt_one;
            else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - c_cnt_one;
        end
    end

    // ---------------- sticky errors + interrupt ----------------
    logic [8:0] w_rx_cnt9, w_thresh9;
    logic       r_int;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_ovr  <= 1'b0;
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
        end else begin
            r_ovr  <= (r_ovr  & ~(w_wr_status & ahb.HWDATA[4])) | (w_rx_push_req & w_rx_full & ~w_rx_pop);
            r_perr <= (r_perr & ~(w_wr_status & ahb.HWDATA[5])) | (w_rx_push_req & r_rx_perr);
            r_ferr <= (r_ferr & ~(w_wr_status & ahb.HWDATA[6])) | (w_rx_push_req & ~r_rx_s2);
        end
    end

    assign w_rx_cnt9 = 9'(r_rx_cnt);
    assign w_thresh9 = {1'b0, (r_thresh == 8'd0) ? 8'd1 : r_thresh};

    always_ff @(posedge HCLK) begin
        if (HRESET) r_int <= 1'b0;
        else        r_int <= (r_rx_ie & ((w_rx_cnt9 >= w_thresh9) | r_ovr | r_perr | r_ferr))
                           | (r_tx_ie & w_tx_empty);
    end

    assign INT_REQ = r_int;

    // ---------------- read mux ----------------
    always_comb begin
        ahb.HRDATA = '0;
        if (r_dp_valid && !r_dp_write) begin
            case (r_dp_addr)
                c_a_data:   ahb.HRDATA = {24'd0, w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp]};
                c_a_status: ahb.HRDATA = {6'd0, 9'(r_tx_cnt), w_rx_cnt9, (r_tx_state != TX_IDLE),
                                          r_ferr, r_perr, r_ovr, w_rx_full, w_rx_empty, w_tx_empty, w_tx_full};
                c_a_ctrl:   ahb.HRDATA = {16'd0, r_thresh, 1'b0, r_tx_ie, r_rx_ie, r_two_stop, r_par, r_rx_en, r_tx_en};
                default:    ahb.HRDATA = {16'd0, r_div};
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ahb_uart_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tb_ahb_uart_fifo
// Brief   : Directed self-checking bench for ahb_uart_fifo.
// Revision: 1.0
// ============================================================================
module tb_ahb_uart_fifo;
    localparam int FIFO_DEPTH = 16;
    localparam int BIT_CYC    = 4;

    logic clk = 1'b0;
    logic rst;
    logic int_req, tx_out, rx_in;
    logic loop_en = 1'b0;
    logic rx_drv  = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    ahb_uart_fifo_if bus ();

    always #5 clk = ~clk;
    assign rx_in = loop_en ? tx_out : rx_drv;

    ahb_uart_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .DEFAULT_DIV(867)) dut (
        .HCLK    (clk),
        .HRESET  (rst),
        .ahb     (bus),
        .INT_REQ (int_req),
        .TX_OUT  (tx_out),
        .RX_IN   (rx_in)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic ahb_write(input logic [15:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = addr;
        @(posedge clk); #1;
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HWDATA = data;
        @(posedge clk); #1;
    endtask

    task automatic ahb_read(input logic [15:0] addr, output logic [31:0] data);
        @(posedge clk); #1;
        bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = addr;
        @(posedge clk); #1;
        bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
        data = bus.HRDATA;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx_drv = b;
        idle(BIT_CYC);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pval, input logic stopv);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (pen) drive_bit(pval);
        drive_bit(stopv);
        rx_drv = 1'b1;
        idle(8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [9:0]  frame;

        bus.HSEL = 1'b0; bus.HADDR = '0; bus.HTRANS = 2'b00; bus.HSIZE = 3'b010;
        bus.HWRITE = 1'b0; bus.HWDATA = '0; bus.HREADY = 1'b1;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(1);

        // Reset state
        check_eq("rst_tx_out", {31'd0, tx_out}, 32'd1);
        check_eq("rst_int", {31'd0, int_req}, 32'd0);
        check_eq("rst_hrdata_idle", bus.HRDATA, 32'd0);
        ahb_read(16'h4, rd); check_eq("rst_status", rd, 32'h0000_0006);
        ahb_read(16'h8, rd); check_eq("rst_ctrl", rd, 32'h0000_0103);
        ahb_read(16'hC, rd); check_eq("rst_baud", rd, 32'd867);
        ahb_read(16'h0, rd); check_eq("rst_data_empty", rd, 32'd0);

        // Single TX frame 0xA5 at DIV=3
        ahb_write(16'hC, 32'd3);
        ahb_read(16'hC, rd); check_eq("baud_wr", rd, 32'd3);
        ahb_write(16'h0, 32'h0000_00A5);
        check_eq("tx_n1_idle", {31'd0, tx_out}, 32'd1);
        frame = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 40; k++) begin
            idle(1);
            check_eq($sformatf("tx_bit_c%0d", k), {31'd0, tx_out}, {31'd0, frame[k / BIT_CYC]});
        end
        idle(1);
        check_eq("tx_after_frame", {31'd0, tx_out}, 32'd1);

        // Loopback: even parity, two stop bits, bytes 0x00..0x0F
        loop_en = 1'b1;
        ahb_write(16'h8, 32'h0000_0117);
        for (int i = 0; i < 16; i++) ahb_write(16'h0, i);
        idle(900);
        ahb_read(16'h4, rd); check_eq("loop_status", rd, 32'h0000_100A);
        for (int i = 0; i < 16; i++) begin
            ahb_read(16'h0, rd);
            check_eq($sformatf("loop_rx%0d", i), rd, i);
        end

        // TX overflow with tx_en=0, then release
        ahb_write(16'h8, 32'h0000_0102);
        for (int i = 0; i <= FIFO_DEPTH; i++) ahb_write(16'h0, 32'h40 + i);
        ahb_read(16'h4, rd); check_eq("ovf_status", rd, 32'h0020_0005);
        ahb_write(16'h8, 32'h0000_0103);
        idle(800);
        ahb_read(16'h4, rd); check_eq("ovf_sent_status", rd, 32'h0000_100A);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            ahb_read(16'h0, rd);
            check_eq($sformatf("ovf_rx%0d", i), rd, 32'h40 + i);
        end
        ahb_read(16'h0, rd); check_eq("ovf_extra_lost", rd, 32'd0);

        // Corruption cases, rx_ie=1, thresh=8, even parity
        loop_en = 1'b0;
        ahb_write(16'h8, 32'h0000_0827);
        send_frame(8'h5A, 1'b1, 1'b1, 1'b1);
        check_eq("perr_int", {31'd0, int_req}, 32'd1);
        ahb_read(16'h4, rd); check_eq("perr_status", rd, 32'h0000_0122);
        ahb_write(16'h4, 32'h0000_0020);
        ahb_read(16'h4, rd); check_eq("perr_cleared", rd, 32'h0000_0102);
        check_eq("perr_int_clr", {31'd0, int_req}, 32'd0);
        ahb_read(16'h0, rd); check_eq("perr_data", rd, 32'h5A);

        send_frame(8'h33, 1'b1, 1'b0, 1'b0);
        check_eq("ferr_int", {31'd0, int_req}, 32'd1);
        ahb_read(16'h4, rd); check_eq("ferr_status", rd, 32'h0000_0142);
        ahb_write(16'h4, 32'h0000_0040);
        ahb_read(16'h0, rd); check_eq("ferr_data", rd, 32'h33);

        rx_drv = 1'b0; idle(1); rx_drv = 1'b1;
        idle(20);
        ahb_read(16'h4, rd); check_eq("glitch_status", rd, 32'h0000_0006);
        check_eq("glitch_int", {31'd0, int_req}, 32'd0);

        // Threshold interrupt, thresh=4, no parity
        ahb_write(16'h8, 32'h0000_0423);
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        send_frame(8'h33, 1'b0, 1'b0, 1'b1);
        check_eq("thr_int_3", {31'd0, int_req}, 32'd0);
        send_frame(8'h44, 1'b0, 1'b0, 1'b1);
        check_eq("thr_int_4", {31'd0, int_req}, 32'd1);
        ahb_read(16'h0, rd); check_eq("thr_data", rd, 32'h11);
        check_eq("thr_int_lag", {31'd0, int_req}, 32'd1);
        idle(1);
        check_eq("thr_int_pop", {31'd0, int_req}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ahb_uart_fifo.md
# ahb_uart_fifo

AHB-Lite slave UART with parametrised TX/RX FIFOs, runtime baud divisor, selectable parity and stop bits, and thresholded interrupt. It is the next-generation serial peripheral on the CM3 expansion target ports (TARGEXPx) and replaces the fixed-format UART. It runs in the CM3/AHB clock domain and drives one interrupt line into EXTINT.

## Interface
- FIFO_DEPTH, 16: entries per FIFO; power of 2, range 4..256.
- DEFAULT_DIV, 867: reset value of BAUD divisor. 100 MHz / 115200 − 1.
- HCLK  in  1  system clock. Single clock domain.
- HRESET  in  1  reset. Synchronous and active-high.
- HSEL  in  1  slave select.
- HADDR  in  16  byte address. Only [3:2] is decoded.
- HTRANS  in  2  transfer type. A transfer is valid when HTRANS[1]=1.
- HSIZE  in  3  ignored. All accesses are treated as 32-bit.
- HWRITE  in  1  write strobe.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus ready (HREADYMUX).
- HREADYOUT  out  1  constant 1. Zero wait states.
- HRDATA  out  32  read data.
- HRESP  out  1  constant 0 (OKAY).
- INT_REQ  out  1  registered interrupt request, level, active-high.
- TX_OUT  out  1  serial transmit. Idle high.
- RX_IN  in  1  serial receive. Asynchronous.

## Operation
- Address phase is captured when HSEL & HREADY & HTRANS[1]. The captured address and write flag act in the following data phase.
- Register map:
  - 0x0 DATA
    - Write pushes HWDATA[7:0] to the TX FIFO. If TX is full the byte is dropped.
    - Read returns the RX head in [7:0] and pops it. If RX is empty, the read returns 0 and nothing is popped.
  - 0x4 STATUS, read:
    - [0] tx_full, [1] tx_empty, [2] rx_empty, [3] rx_full
    - [4] rx_overrun, [5] parity_err, [6] frame_err
    - [7] tx_busy
    - [16:8] rx_count, [25:17] tx_count
  - 0x4 STATUS, write: writing 1 to bits [6:4] clears them. Bits [6:4] are sticky.
  - 0x8 CTRL, read/write, reset value 0x0000_0103:
    - [0] tx_en, [1] rx_en
    - [3:2] parity: 00 none, 01 even, 10 odd, 11 none
    - [4] two stop bits
    - [5] rx_ie, [6] tx_ie
    - [15:8] rx_thresh; a value of 0 is treated as 1
  - 0xC BAUD, read/write: [15:0] DIV. Bit period is DIV+1 cycles. DIV<3 is clamped to 3.
- Frame format: start(0), 8 data bits LSB first, optional parity, 1 or 2 stop bits(1).
- TX FSM: IDLE → START → DATA(8) → PARITY (skipped when parity is none) → STOP(1 or 2) → IDLE.
  - A frame starts from IDLE when tx_en=1 and the TX FIFO is non-empty. The FIFO pops on entering START.
  - CTRL and BAUD are latched at START. Changes take effect on the next frame.
  - Clearing tx_en mid-frame finishes the current frame.
- RX path: RX_IN goes through a 2-flop synchroniser (reset value 1).
- RX FSM: IDLE → START → DATA → PARITY → STOP → IDLE.
  - A falling edge while IDLE with rx_en=1 enters START. The line is re-checked at (DIV+1)/2 cycles. If it is high, the FSM returns to IDLE and nothing is pushed (glitch reject).
  - Each subsequent bit is sampled one full period later.
  - Only the first stop bit is checked. A 0 there sets frame_err.
  - A parity mismatch sets parity_err.
  - The byte is pushed even when it has an error.
  - If RX is full the byte is dropped and rx_overrun is set.
- INT_REQ, registered:
  - rx_ie & (rx_count ≥ rx_thresh | any sticky error)
  - OR tx_ie & tx_empty
- Simultaneous events:
  - A push and a pop on a full FIFO in the same cycle both succeed; the count is unchanged.
  - A push and a pop on an empty FIFO: the pop returns 0 and the push is stored.
  - A sticky error set and a W1C clear in the same cycle: set wins.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap. Counts are log2(FIFO_DEPTH)+1 bits.

## Timing
- Reset values:
  - TX_OUT=1, INT_REQ=0, HRDATA=0.
  - FIFOs empty. Both FSMs IDLE. Sticky bits 0.
  - CTRL=0x103, BAUD=DEFAULT_DIV.
- HRDATA is driven combinationally during the data phase from the captured address. It is 0 when no read is in progress.
- An RX pop and all register updates take effect at the end of the data phase.
- TX latency: a DATA write in data-phase cycle N, with an empty FIFO and TX idle, drives TX_OUT low from cycle N+2. Each bit lasts exactly DIV+1 cycles.
- RX latency: RX_IN to the synchronised value is 2 cycles. rx_count increments 1 cycle after the mid-stop sample.
- INT_REQ lags its condition by 1 cycle.
- HRESET mid-frame:
  - TX_OUT returns to 1 on the next edge. The partial frame is abandoned.
  - The RX FSM returns to IDLE.

## Test plan
- Reset, then read all 4 registers → STATUS=0x0000_0006, CTRL=0x103, BAUD=867. TX_OUT=1.
- DIV=3, no parity, 1 stop, write 0xA5 → TX_OUT low at N+2, then bits 1,0,1,0,0,1,0,1, then 1. 40 cycles total (10 bits × 4 cycles).
- Loopback TX_OUT→RX_IN, even parity, 2 stop bits, send 0x00..0x0F → RX data matches, no error bits, rx_count=16.
- Write FIFO_DEPTH+1 bytes while tx_en=0 → tx_full=1, tx_count=FIFO_DEPTH, extra byte lost. Set tx_en → exactly FIFO_DEPTH frames sent.
- Corruption, each with rx_ie=1:
  - Wrong parity bit → parity_err=1 and INT_REQ=1. W1C 0x20 clears it.
  - Stop=0 → frame_err=1.
  - A 1-cycle low glitch → no push.
- rx_thresh=4, rx_ie=1, receive 3 bytes → INT_REQ=0. 4th byte → INT_REQ=1. One DATA read → INT_REQ=0 the cycle after.
